// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch unit.
// Memory answers combinationally in the cycle imem_req and imem_ready meet.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage with redirect, stall and halt.
// One instruction in flight: fetch, present until consumed, repeat.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         halt,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic [6:0]   op,
  output logic [2:0]   funct3,
  output logic [11:0]  imm12,
  output logic         halted,
  output logic [31:0]  instr_count
);

  typedef enum logic [1:0] {
    FETCH,
    VALID,
    HALTED
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] target;
  logic        load;
  logic        consume;

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    load     = 1'b0;
    consume  = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_nx = target;
        end else if (imem.imem_ready) begin
          load     = 1'b1;
          pc_nx    = pc + 32'd4;
          state_nx = VALID;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_nx    = target;
          state_nx = FETCH;
        end else if (!stall) begin
          consume  = 1'b1;
          state_nx = halt ? HALTED : FETCH;
        end
      end
      HALTED: state_nx = HALTED;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0013;
      instr_pc    <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (load) begin
        instr    <= imem.imem_rdata;
        instr_pc <= pc;
      end
      if (consume) instr_count <= instr_count + 32'd1;
    end
  end

  // Gate on rst_n so no request escapes while reset is held.
  assign imem.imem_req  = rst_n && (state == FETCH);
  assign imem.imem_addr = {pc[31:2], 2'b00};

  assign instr_valid = (state == VALID);
  assign halted      = (state == HALTED);
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign imm12       = instr[31:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model plus directed
// and randomized stimulus, compared every cycle on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [11:0] imm12;
  logic        halted;
  logic [31:0] instr_count;

  logic        ov_en;
  logic [31:0] ov_data;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if bus ();

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus.master),
    .stall          (stall),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .imm12          (imm12),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  function automatic logic [31:0] word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = ov_en ? ov_data : word(bus.imem_addr);

  // Reference model: one instruction buffer and a stop flag.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_count;
  logic        m_have;
  logic        m_stop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'h0;
      m_instr <= 32'h0000_0013;
      m_ipc   <= 32'h0;
      m_count <= 32'h0;
      m_have  <= 1'b0;
      m_stop  <= 1'b0;
    end else if (!m_stop) begin
      if (redirect_valid) begin
        m_pc   <= redirect_pc & 32'hFFFF_FFFC;
        m_have <= 1'b0;
      end else if (m_have) begin
        if (!stall) begin
          m_count <= m_count + 1;
          m_have  <= 1'b0;
          m_stop  <= halt;
        end
      end else if (bus.imem_ready) begin
        m_instr <= ov_en ? ov_data : word(m_pc);
        m_ipc   <= m_pc;
        m_pc    <= m_pc + 4;
        m_have  <= 1'b1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic exp_req;
  assign exp_req = rst_n && !m_have && !m_stop;

  always @(negedge clk) begin
    chk("req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("addr", bus.imem_addr, m_pc);
    chk("valid", 32'(instr_valid), 32'(m_have));
    chk("halted", 32'(halted), 32'(m_stop));
    chk("count", instr_count, m_count);
    chk("instr", instr, m_instr);
    chk("ipc", instr_pc, m_ipc);
    chk("fields", {9'd0, imm12, funct3, op},
        {9'd0, m_instr[31:20], m_instr[14:12], m_instr[6:0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.imem_ready = 1'b0;
    stall          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ov_en          = 1'b0;
    ov_data        = 32'h0;
    repeat (3) tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // First fetch out of reset.
    ov_en          = 1'b1;
    ov_data        = 32'h0050_0093;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);
    tick();
    ov_en = 1'b0;
    chk("p_valid", 32'(instr_valid), 32'd1);
    chk("p_ipc", instr_pc, 32'd0);
    chk("p_op", 32'(op), 32'h13);
    chk("p_imm", 32'(imm12), 32'h005);
    tick();
    chk("p_count", instr_count, 32'd1);
    chk("p_next", bus.imem_addr, 32'd4);

    // Memory wait states.
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_req", 32'(bus.imem_req), 32'd1);
      chk("w_addr", bus.imem_addr, 32'd4);
      chk("w_valid", 32'(instr_valid), 32'd0);
    end
    bus.imem_ready = 1'b1;
    stall          = 1'b1;
    halt           = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    chk("w_done", instr_pc, 32'd4);
    chk("w_data", instr, word(32'd4));

    // Halt held off by stall, then taken.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s_valid", 32'(instr_valid), 32'd1);
      chk("s_count", instr_count, 32'd1);
      chk("s_halt", 32'(halted), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_count", instr_count, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_stay", 32'(halted), 32'd1);
      chk("h_req", 32'(bus.imem_req), 32'd0);
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;

    // Reset from HALTED, mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    chk("r_halted", 32'(halted), 32'd0);
    chk("r_count", instr_count, 32'd0);
    chk("r_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("r_addr", bus.imem_addr, 32'd0);
    chk("r_req1", 32'(bus.imem_req), 32'd1);

    // Redirect in VALID beats halt and stall.
    stall = 1'b1;
    tick();
    chk("d_valid0", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    halt           = 1'b1;
    tick();
    chk("d_valid", 32'(instr_valid), 32'd0);
    chk("d_halted", 32'(halted), 32'd0);
    chk("d_addr", bus.imem_addr, 32'h100);
    chk("d_count", instr_count, 32'd0);
    halt = 1'b0;

    // Redirect to the top word, then wrap.
    bus.imem_ready = 1'b0;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    chk("t_addr", bus.imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    bus.imem_ready = 1'b1;
    tick();
    chk("t_ipc", instr_pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    tick();
    chk("t_wrap", bus.imem_addr, 32'h0);
    chk("t_count", instr_count, 32'd1);

    // Redirect colliding with a completing transfer.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    chk("c_valid", 32'(instr_valid), 32'd0);
    chk("c_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("c_addr", bus.imem_addr, 32'h200);
    redirect_valid = 1'b0;

    // Mixed traffic; reset whenever the model stops.
    for (int i = 0; i < 400; i++) begin
      bus.imem_ready = ($urandom_range(3) != 0);
      stall          = ($urandom_range(2) == 0);
      halt           = ($urandom_range(15) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = $urandom;
      rst_n          = !(m_stop && ($urandom_range(1) == 0));
      tick();
    end
    rst_n = 1'b1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address (bits [1:0] always 0).
REQ-006 SHALL have port imem_ready  input  1  memory accepts and returns data in the same cycle as imem_req.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid only when imem_req and imem_ready are both 1.
REQ-008 SHALL have port stall  input  1  downstream not accepting the presented instruction.
REQ-009 SHALL have port halt  input  1  decoder indication that the presented instruction is ECALL/EBREAK.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken, squash and refetch.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
REQ-012 SHALL have port instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-013 SHALL have port instr  output  32  registered instruction word.
REQ-014 SHALL have port instr_pc  output  32  address of instr.
REQ-015 SHALL have ports op  output  7, funct3  output  3, imm12  output  12  decoder fields: instr[6:0], instr[14:12], instr[31:20], combinational from the instr register.
REQ-016 SHALL have port halted  output  1  fetch permanently stopped.
REQ-017 SHALL have port instr_count  output  32  number of instructions consumed downstream.

Function
REQ-018 SHALL implement states FETCH, VALID, HALTED, plus a 32-bit pc register.
REQ-019 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; a transfer completes when imem_ready=1.
REQ-020 On a completed transfer without redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, next state VALID; instr_valid=1 the following cycle (one-cycle fetch latency).
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 VALID: imem_req=0, instr_valid=1; instr, instr_pc held stable while stall=1.
REQ-023 Instruction consumed in VALID when stall=0; then instr_count<=instr_count+1 (wraps modulo 2^32).
REQ-024 Consumed with halt=1 and redirect_valid=0 -> HALTED; consumed with halt=0 -> FETCH.
REQ-025 HALT SHALL be ignored while stall=1 (halt acts only when the instruction is consumed).
REQ-026 redirect_valid=1 in FETCH or VALID: pc<={redirect_pc[31:2],2'b00}, next state FETCH, instr_valid=0 next cycle.
REQ-027 Redirect coinciding with a completed transfer: imem_rdata discarded, instr/instr_pc unchanged.
REQ-028 Redirect in VALID overrides halt and stall; the presented instruction is squashed and not counted.
REQ-029 HALTED: imem_req=0, instr_valid=0, halted=1; redirect_valid, stall, halt ignored; exit only via reset.
REQ-030 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0, except on redirect.

Reset
REQ-031 rst_n=0 SHALL immediately force: state FETCH, pc=RESET_PC, imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, halted=0, instr_count=0.
REQ-032 imem_req SHALL be 0 while rst_n=0 and rise to 1 with imem_addr=RESET_PC in the first cycle after deassertion.
REQ-033 Reset asserted mid-transfer or in HALTED SHALL abandon all state with no output glitch beyond REQ-031 values.

Verification
REQ-034 Reset release, imem_ready=1, rdata=32'h00500093, stall=0 -> next cycle instr_valid=1, instr_pc=0, op=7'h13, imm12=12'h005; instr_count=1 after consumption; next imem_addr=4.
REQ-035 imem_ready=0 for 3 cycles in FETCH -> imem_req=1, imem_addr constant, instr_valid=0; completes on 4th cycle.
REQ-036 VALID with stall=1 for 5 cycles, halt=1 -> instr held, no state change, count unchanged; stall=0 -> HALTED, halted=1, imem_req=0 thereafter.
REQ-037 VALID with redirect_valid=1, redirect_pc=32'h0000_0103, halt=1 -> not halted, instr_valid=0 next cycle, imem_addr=32'h0000_0100, count unchanged.
REQ-038 Redirect to 32'hFFFF_FFFC, transfer completes -> instr_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-039 rst_n pulsed low in HALTED -> halted=0, instr_count=0, fetch resumes at RESET_PC.
